// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: ALU control codes and register-file constants.
package mips_pkg;

    localparam int CSIG_W   = 4;
    localparam int REG_ZERO = 0;

    typedef enum logic [CSIG_W-1:0] {
        ALU_OR   = 4'h0,
        ALU_AND  = 4'h1,
        ALU_XOR  = 4'h2,
        ALU_SLL  = 4'h3,
        ALU_SRL  = 4'h4,
        ALU_SUB  = 4'h5,
        ALU_ADD  = 4'h6,
        ALU_NOR  = 4'h7,
        ALU_NAND = 4'h8,
        ALU_SLT  = 4'h9,
        ALU_MUL  = 4'hA,
        ALU_CLR  = 4'hB,
        ALU_SET  = 4'hC,
        ALU_ADDR = 4'hD,
        ALU_ANDN = 4'hE,
        ALU_XNOR = 4'hF
    } alu_op_e;

endpackage

// File: rtl/fwd_mux.sv
// Operand forwarding select: EX/MEM result beats MEM/WB data beats register-file data.
module fwd_mux
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] idx_i,
    input  logic [DATA_W-1:0] reg_data_i,
    input  logic              exm_we_i,
    input  logic [REG_AW-1:0] exm_rd_i,
    input  logic [DATA_W-1:0] exm_data_i,
    input  logic              wb_we_i,
    input  logic [REG_AW-1:0] wb_rd_i,
    input  logic [DATA_W-1:0] wb_data_i,
    output logic [DATA_W-1:0] data_o
);

    logic exm_hit;
    logic wb_hit;

    // $zero is hard-wired, so a write targeting it must never be forwarded.
    assign exm_hit = exm_we_i && (exm_rd_i != REG_AW'(REG_ZERO)) && (exm_rd_i == idx_i);
    assign wb_hit  = wb_we_i  && (wb_rd_i  != REG_AW'(REG_ZERO)) && (wb_rd_i  == idx_i);

    always_comb begin
        data_o = reg_data_i;
        if (exm_hit) begin
            data_o = exm_data_i;
        end else if (wb_hit) begin
            data_o = wb_data_i;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and operand forwarding.
// Define HAZARD_COUNT_EN to add the saturating stall_cnt output.
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int IMM_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_rt_used,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [IMM_W-1:0]  id_imm,
    input  logic              id_use_imm,
    input  logic              id_sign_ext,
    input  logic [CSIG_W-1:0] id_alu_op,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              flush,
    input  logic              ex_ready,
    input  logic              exm_reg_write,
    input  logic [REG_AW-1:0] exm_rd,
    input  logic [DATA_W-1:0] exm_result,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_a,
    output logic [DATA_W-1:0] ex_b,
    output logic [CSIG_W-1:0] ex_csig,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              stall
`ifdef HAZARD_COUNT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    logic              valid_q,     valid_d;
    logic [REG_AW-1:0] rs_q,        rs_d;
    logic [REG_AW-1:0] rt_q,        rt_d;
    logic [REG_AW-1:0] rd_q,        rd_d;
    logic [DATA_W-1:0] rs_data_q,   rs_data_d;
    logic [DATA_W-1:0] rt_data_q,   rt_data_d;
    logic [DATA_W-1:0] imm_q,       imm_d;
    logic              use_imm_q,   use_imm_d;
    alu_op_e           csig_q,      csig_d;
    logic              reg_write_q, reg_write_d;
    logic              mem_read_q,  mem_read_d;

    logic              hazard;
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] fwd_a;
    logic [DATA_W-1:0] fwd_b;

    assign hazard = valid_q && mem_read_q && (rd_q != REG_AW'(REG_ZERO)) && id_valid &&
                    ((rd_q == id_rs) || (id_rt_used && (rd_q == id_rt)));

    assign stall    = hazard;
    assign id_ready = ex_ready && !hazard && !flush;

    assign imm_ext = {{(DATA_W-IMM_W){id_sign_ext & id_imm[IMM_W-1]}}, id_imm};

    always_comb begin
        valid_d     = valid_q;
        rs_d        = rs_q;
        rt_d        = rt_q;
        rd_d        = rd_q;
        rs_data_d   = rs_data_q;
        rt_data_d   = rt_data_q;
        imm_d       = imm_q;
        use_imm_d   = use_imm_q;
        csig_d      = csig_q;
        reg_write_d = reg_write_q;
        mem_read_d  = mem_read_q;

        // Bubbles clear the whole record so stale indices cannot trigger hazards or forwarding.
        if (flush || (ex_ready && (hazard || !id_valid))) begin
            valid_d     = 1'b0;
            rs_d        = '0;
            rt_d        = '0;
            rd_d        = '0;
            rs_data_d   = '0;
            rt_data_d   = '0;
            imm_d       = '0;
            use_imm_d   = 1'b0;
            csig_d      = ALU_OR;
            reg_write_d = 1'b0;
            mem_read_d  = 1'b0;
        end else if (ex_ready) begin
            valid_d     = 1'b1;
            rs_d        = id_rs;
            rt_d        = id_rt;
            rd_d        = id_rd;
            rs_data_d   = id_rs_data;
            rt_data_d   = id_rt_data;
            imm_d       = imm_ext;
            use_imm_d   = id_use_imm;
            csig_d      = alu_op_e'(id_alu_op);
            reg_write_d = id_reg_write;
            mem_read_d  = id_mem_read;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            rs_q        <= '0;
            rt_q        <= '0;
            rd_q        <= '0;
            rs_data_q   <= '0;
            rt_data_q   <= '0;
            imm_q       <= '0;
            use_imm_q   <= 1'b0;
            csig_q      <= ALU_OR;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            rs_q        <= rs_d;
            rt_q        <= rt_d;
            rd_q        <= rd_d;
            rs_data_q   <= rs_data_d;
            rt_data_q   <= rt_data_d;
            imm_q       <= imm_d;
            use_imm_q   <= use_imm_d;
            csig_q      <= csig_d;
            reg_write_q <= reg_write_d;
            mem_read_q  <= mem_read_d;
        end
    end

    fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_a (
        .idx_i      (rs_q),
        .reg_data_i (rs_data_q),
        .exm_we_i   (exm_reg_write),
        .exm_rd_i   (exm_rd),
        .exm_data_i (exm_result),
        .wb_we_i    (wb_reg_write),
        .wb_rd_i    (wb_rd),
        .wb_data_i  (wb_data),
        .data_o     (fwd_a)
    );

    fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_b (
        .idx_i      (rt_q),
        .reg_data_i (rt_data_q),
        .exm_we_i   (exm_reg_write),
        .exm_rd_i   (exm_rd),
        .exm_data_i (exm_result),
        .wb_we_i    (wb_reg_write),
        .wb_rd_i    (wb_rd),
        .wb_data_i  (wb_data),
        .data_o     (fwd_b)
    );

    assign ex_valid     = valid_q;
    assign ex_a         = fwd_a;
    assign ex_b         = use_imm_q ? imm_q : fwd_b;
    assign ex_csig      = csig_q;
    assign ex_rd        = rd_q;
    assign ex_reg_write = reg_write_q & valid_q;
    assign ex_mem_read  = mem_read_q & valid_q;

`ifdef HAZARD_COUNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (hazard && !flush && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule
